simple_dma_controller: RTL and testbench
========================================

SIMPLE_DMA_CONTROLLER -- requirements
Module: simple_dma_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port dma_rqst, input, 1 bit: transfer request from device.
REQ-004 SHALL have port dma_rd_wr, input, 1 bit: direction; 1 = memory-to-device read, 0 = device-to-memory write.
REQ-005 SHALL have port dma_start_address, input, 16 bits: starting byte address.
REQ-006 SHALL have port dma_num_words, input, 16 bits: word count.
REQ-007 SHALL have port dev_ack, input, 1 bit: device ready for the next word.
REQ-008 SHALL have port dev_out, input, 16 bits: write data from device.
REQ-009 SHALL have port dev_in, output, 16 bits: read data to device.
REQ-010 SHALL have port dma_ack, output, 1 bit: one-cycle per-word completion strobe.
REQ-011 SHALL have port dma_end_flag, output, 1 bit: transfer complete.
REQ-012 SHALL have port dma_error, output, 1 bit: transfer terminated by timeout.
REQ-013 SHALL have port mem_addr, output, 16 bits: memory byte address, bit 0 always 0.
REQ-014 SHALL have port mem_en, output, 1 bit: memory access request.
REQ-015 SHALL have port mem_we, output, 2 bits: byte write enables.
REQ-016 SHALL have port mem_din, output, 16 bits: data to memory.
REQ-017 SHALL have port mem_dout, input, 16 bits: data from memory, valid one cycle after an accepted read.
REQ-018 SHALL have port mem_ready, input, 1 bit: memory accepts the access this cycle.

Function
REQ-019 SHALL implement the states IDLE, WAIT_DEV, MEM_REQ, RD_WAIT, ACK and DONE.
REQ-020 In IDLE with dma_rqst=1, SHALL latch address (bit0 cleared), count and direction, then go to WAIT_DEV, or go to DONE directly if dma_num_words=0.
REQ-021 SHALL ignore dma_start_address, dma_num_words and dma_rd_wr after latching until the controller returns to IDLE.
REQ-022 In WAIT_DEV, dma_rqst=0 SHALL cause a return to IDLE with no end flag (abort); otherwise dev_ack=1 SHALL cause a move to MEM_REQ, and on a write dev_out SHALL be captured into mem_din that same cycle.
REQ-023 In MEM_REQ, mem_en=1, mem_addr=current address and mem_we=2'b11 (write) or 2'b00 (read) SHALL be held until mem_ready=1, then the controller SHALL go to RD_WAIT (read) or ACK (write); dma_rqst SHALL NOT be checked in this state.
REQ-024 RD_WAIT SHALL last exactly one cycle, register mem_dout into dev_in, and then go to ACK.
REQ-025 In ACK, dma_ack SHALL be 1 for exactly one cycle, the address SHALL advance by 2 modulo 2^16 (0xFFFE wraps to 0x0000), and the count SHALL decrement; a count reaching 0 SHALL lead to DONE, else to WAIT_DEV.
REQ-026 dev_in SHALL remain stable from RD_WAIT until the next RD_WAIT, so it is valid whenever dma_ack=1.
REQ-027 dev_ack SHALL be sampled only in WAIT_DEV, so a level held high from the previous word is not consumed before the next WAIT_DEV.
REQ-028 In DONE, dma_end_flag SHALL be 1 and SHALL remain 1 until dma_rqst=0, after which the controller SHALL return to IDLE the next cycle.
REQ-029 Outside MEM_REQ, mem_en SHALL be 0 and mem_we SHALL be 2'b00.
REQ-030 Per word, minimum latency SHALL be 3 cycles for a write (WAIT_DEV, MEM_REQ, ACK) and 4 cycles for a read.

Reset
REQ-031 With reset=1 at a clock edge, state SHALL be IDLE, all outputs 0, and the internal address and count 0, including mid-transfer.
REQ-032 Reset SHALL override every concurrent event; no dma_ack SHALL be issued in the cycle after a reset edge.

Configuration
REQ-033 Macro DMA_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to WAIT_DEV and increment each cycle there.
REQ-034 When that counter reaches 255 with dev_ack=0, the controller SHALL go to DONE with dma_error=1; dma_error SHALL clear on the return to IDLE.
REQ-035 Macro DMA_TIMEOUT_EN not defined: no counter SHALL exist, dma_error SHALL be constant 0, and WAIT_DEV SHALL wait indefinitely.

Verification
REQ-036 Read of 3 words from 0x0200 (memory 0x1111, 0x2222, 0x3333) with dev_ack=1 and mem_ready=1 -> mem_addr 0x0200, 0x0202, 0x0204; dev_in equals each value at its dma_ack; dma_end_flag=1 after the third dma_ack.
REQ-037 Write of 2 words to 0x0300 with dev_out 0xA5A5 then 0x5A5A, dev_ack pulsed per word -> mem_we=2'b11 with those data at 0x0300 and 0x0302; 2 dma_ack pulses; end flag.
REQ-038 Read of 2 words from 0xFFFE -> addresses 0xFFFE then 0x0000.
REQ-039 dma_num_words=0 -> DONE on the next cycle, with no mem_en and no dma_ack.
REQ-040 mem_ready held 0 for 5 cycles in MEM_REQ -> mem_en and mem_addr held stable, with a single dma_ack.
REQ-041 dma_rqst dropped in WAIT_DEV after 1 of 4 words -> IDLE with no end flag; with DMA_TIMEOUT_EN, dev_ack held 0 -> dma_error=1 and dma_end_flag=1 after 255 WAIT_DEV cycles.

Source files
------------

// File: rtl/simple_dma_controller_if.sv
// Device and memory signal bundle for simple_dma_controller.
// master: the DMA controller; slave: the device/memory environment that drives it.
interface simple_dma_controller_if;
    logic        dma_rqst;
    logic        dma_rd_wr;
    logic [15:0] dma_start_address;
    logic [15:0] dma_num_words;
    logic        dev_ack;
    logic [15:0] dev_out;
    logic [15:0] dev_in;
    logic        dma_ack;
    logic        dma_end_flag;
    logic        dma_error;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [1:0]  mem_we;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_ready;

    modport master (
        input  dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
               dev_ack, dev_out, mem_dout, mem_ready,
        output dev_in, dma_ack, dma_end_flag, dma_error,
               mem_addr, mem_en, mem_we, mem_din
    );

    modport slave (
        output dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
               dev_ack, dev_out, mem_dout, mem_ready,
        input  dev_in, dma_ack, dma_end_flag, dma_error,
               mem_addr, mem_en, mem_we, mem_din
    );
endinterface

// File: rtl/simple_dma_controller.sv
// Single-channel word DMA between a device handshake port and a 16-bit memory port.
// Optional WAIT_DEV timeout enabled by defining DMA_TIMEOUT_EN.
module simple_dma_controller (
    input  logic                      clk,
    input  logic                      reset,
    simple_dma_controller_if.master   bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned DW = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_DEV = 3'd1,
        MEM_REQ  = 3'd2,
        RD_WAIT  = 3'd3,
        ACK      = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic [DW-1:0]   din_q, din_d;
    logic [DW-1:0]   dev_in_q, dev_in_d;
    logic            ack_q, ack_d;
    logic            end_q, end_d;
    logic            mem_en_q, mem_en_d;
    logic [1:0]      we_q, we_d;
`ifdef DMA_TIMEOUT_EN
    localparam int unsigned TW = 8;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    // Next-state and datapath; output flops are decoded from the next state.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        din_d    = din_q;
        dev_in_d = dev_in_q;
`ifdef DMA_TIMEOUT_EN
        err_d    = err_q;
        tmo_d    = (state_q == WAIT_DEV) ? tmo_q + TW'(1) : '0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.dma_rqst) begin
                    addr_d  = bus.dma_start_address & AW'(16'hFFFE);
                    cnt_d   = bus.dma_num_words;
                    rd_d    = bus.dma_rd_wr;
                    state_d = (bus.dma_num_words == '0) ? DONE : WAIT_DEV;
                end
            end
            WAIT_DEV: begin
                if (!bus.dma_rqst) begin
                    state_d = IDLE;
                end else if (bus.dev_ack) begin
                    state_d = MEM_REQ;
                    if (!rd_q) din_d = bus.dev_out;
                end
`ifdef DMA_TIMEOUT_EN
                else if (tmo_q == '1) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
`endif
            end
            MEM_REQ: begin
                if (bus.mem_ready) state_d = rd_q ? RD_WAIT : ACK;
            end
            RD_WAIT: begin
                dev_in_d = bus.mem_dout;
                state_d  = ACK;
            end
            ACK: begin
                addr_d  = addr_q + AW'(2);
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? DONE : WAIT_DEV;
            end
            DONE: begin
                if (!bus.dma_rqst) begin
                    state_d = IDLE;
`ifdef DMA_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        ack_d    = (state_d == ACK);
        end_d    = (state_d == DONE);
        mem_en_d = (state_d == MEM_REQ);
        we_d     = (mem_en_d && !rd_d) ? 2'b11 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            din_q    <= '0;
            dev_in_q <= '0;
            ack_q    <= 1'b0;
            end_q    <= 1'b0;
            mem_en_q <= 1'b0;
            we_q     <= 2'b00;
`ifdef DMA_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            din_q    <= din_d;
            dev_in_q <= dev_in_d;
            ack_q    <= ack_d;
            end_q    <= end_d;
            mem_en_q <= mem_en_d;
            we_q     <= we_d;
`ifdef DMA_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.dev_in       = dev_in_q;
    assign bus.dma_ack      = ack_q;
    assign bus.dma_end_flag = end_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_din      = din_q;
`ifdef DMA_TIMEOUT_EN
    assign bus.dma_error    = err_q;
`else
    assign bus.dma_error    = 1'b0;
`endif
endmodule

// File: tb/tb_simple_dma_controller.sv
// Randomized bench for simple_dma_controller against a transaction-level memory/device model.
// Define DMA_TIMEOUT_EN on both RTL and bench to exercise the timeout path.
module tb_simple_dma_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    simple_dma_controller_if bus ();
    simple_dma_controller dut (.clk(clk), .reset(reset), .bus(bus));

    int errs   = 0;
    int checks = 0;
    logic [15:0] mem_m [logic [15:0]];
    logic [15:0] wdata_q [$];
    int stall_left = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.dma_rqst          = 1'b0;
        bus.dma_rd_wr         = 1'b0;
        bus.dma_start_address = 16'h0;
        bus.dma_num_words     = 16'h0;
        bus.dev_ack           = 1'b0;
        bus.dev_out           = 16'h0;
        bus.mem_dout          = 16'h0;
        bus.mem_ready         = 1'b0;
    endtask

    task automatic check_zero(input string p);
        check_eq({p, "_ack"},    32'(bus.dma_ack), 0);
        check_eq({p, "_end"},    32'(bus.dma_end_flag), 0);
        check_eq({p, "_err"},    32'(bus.dma_error), 0);
        check_eq({p, "_mem_en"}, 32'(bus.mem_en), 0);
        check_eq({p, "_mem_we"}, 32'(bus.mem_we), 0);
        check_eq({p, "_addr"},   32'(bus.mem_addr), 0);
        check_eq({p, "_din"},    32'(bus.mem_din), 0);
        check_eq({p, "_dev_in"}, 32'(bus.dev_in), 0);
    endtask

    // One complete transfer; called and returns just after a rising edge.
    task automatic run_xfer(input bit rd, input logic [15:0] start, input int n,
                            input int ack_pct, input int rdy_pct,
                            output int end_cyc, output int first_en);
        logic [15:0] ea [$];
        logic [15:0] ed [$];
        logic [15:0] a;
        logic [15:0] pend_addr;
        bit rd_pend, done;
        int acks, accepted, cyc;
        for (int i = 0; i < n; i++) begin
            a = (start & 16'hFFFE) + 16'(2 * i);
            ea.push_back(a);
            if (rd) begin
                if (!mem_m.exists(a)) mem_m[a] = 16'($urandom);
                ed.push_back(mem_m[a]);
            end else begin
                ed.push_back((wdata_q.size() > 0) ? wdata_q.pop_front() : 16'($urandom));
            end
        end
        bus.dma_rqst          = 1'b1;
        bus.dma_rd_wr         = rd;
        bus.dma_start_address = start;
        bus.dma_num_words     = 16'(n);
        rd_pend = 1'b0; done = 1'b0; pend_addr = 16'h0;
        acks = 0; accepted = 0; cyc = 0; end_cyc = -1; first_en = 0;
        while (!done && cyc < 5000) begin
            bus.dev_ack  = (int'($urandom_range(99)) < ack_pct);
            bus.dev_out  = (acks < n) ? ed[acks] : 16'($urandom);
            bus.mem_dout = rd_pend ? mem_m[pend_addr] : 16'($urandom);
            rd_pend = 1'b0;
            if (bus.mem_en && stall_left > 0) begin
                bus.mem_ready = 1'b0;
                stall_left--;
            end else begin
                bus.mem_ready = (int'($urandom_range(99)) < rdy_pct);
            end
            @(negedge clk);
            if (bus.mem_en) begin
                if (accepted < n) check_eq("mem_addr", 32'(bus.mem_addr), 32'(ea[accepted]));
                else check_eq("extra_mem_en", 32'(bus.mem_en), 0);
                check_eq("mem_we", 32'(bus.mem_we), rd ? 0 : 3);
                if (accepted == 0) first_en++;
                if (bus.mem_ready && accepted < n) begin
                    if (!rd) begin
                        check_eq("mem_din", 32'(bus.mem_din), 32'(ed[accepted]));
                        mem_m[ea[accepted]] = ed[accepted];
                    end else begin
                        rd_pend   = 1'b1;
                        pend_addr = ea[accepted];
                    end
                    accepted++;
                end
            end else begin
                check_eq("mem_we_idle", 32'(bus.mem_we), 0);
            end
            if (bus.dma_ack) begin
                check_eq("ack_after_access", accepted, acks + 1);
                if (acks < n) begin
                    if (rd) check_eq("dev_in", 32'(bus.dev_in), 32'(ed[acks]));
                end else check_eq("extra_ack", 32'(bus.dma_ack), 0);
                acks++;
            end
            if (bus.dma_end_flag) begin
                done    = 1'b1;
                end_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("end_seen", 32'(done), 1);
        check_eq("ack_count", acks, n);
        check_eq("access_count", accepted, n);
        check_eq("err_normal", 32'(bus.dma_error), 0);
        bus.dma_rqst  = 1'b0;
        bus.dev_ack   = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("end_hold", 32'(bus.dma_end_flag), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("end_clear", 32'(bus.dma_end_flag), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_abort();
        bit seen;
        int it;
        bus.dma_rqst = 1'b1; bus.dma_rd_wr = 1'b1;
        bus.dma_start_address = 16'h0800; bus.dma_num_words = 16'd4;
        bus.dev_ack = 1'b1; bus.mem_ready = 1'b1;
        seen = 1'b0;
        for (it = 0; it < 20 && !seen; it++) begin
            @(negedge clk);
            if (bus.dma_ack) seen = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("abort_first_ack", 32'(seen), 1);
        bus.dma_rqst = 1'b0; bus.dev_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("abort_end", 32'(bus.dma_end_flag), 0);
            check_eq("abort_mem_en", 32'(bus.mem_en), 0);
            check_eq("abort_ack", 32'(bus.dma_ack), 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_mid_reset();
        bus.dma_rqst = 1'b1; bus.dma_rd_wr = 1'b1;
        bus.dma_start_address = 16'h0900; bus.dma_num_words = 16'd5;
        bus.dev_ack = 1'b1; bus.mem_ready = 1'b1; bus.mem_dout = 16'hBEEF;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_dev_in", 32'(bus.dev_in), 32'h0000BEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b0; bus.dma_rqst = 1'b0; bus.dev_ack = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ack", 32'(bus.dma_ack), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("post_rst_mem_en", 32'(bus.mem_en), 0);
        @(posedge clk); #1;
    endtask

`ifdef DMA_TIMEOUT_EN
    task automatic run_timeout();
        bit seen;
        int it, hit;
        bus.dma_rqst = 1'b1; bus.dma_rd_wr = 1'b0;
        bus.dma_start_address = 16'h0A00; bus.dma_num_words = 16'd2;
        bus.dev_ack = 1'b0; bus.mem_ready = 1'b0;
        seen = 1'b0; hit = -1;
        for (it = 0; it < 400 && !seen; it++) begin
            @(negedge clk);
            if (bus.dma_end_flag) begin
                seen = 1'b1;
                hit  = it;
                check_eq("tmo_err", 32'(bus.dma_error), 1);
            end
            @(posedge clk); #1;
        end
        check_eq("tmo_seen", 32'(seen), 1);
        check_eq("tmo_window", 32'(hit >= 256 && hit <= 257), 1);
        bus.dma_rqst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("tmo_err_clear", 32'(bus.dma_error), 0);
        check_eq("tmo_end_clear", 32'(bus.dma_end_flag), 0);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        int ec, fe, n;
        bit rd;
        drive_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        mem_m[16'h0200] = 16'h1111; mem_m[16'h0202] = 16'h2222; mem_m[16'h0204] = 16'h3333;
        run_xfer(1'b1, 16'h0200, 3, 100, 100, ec, fe);
        check_eq("rd3_latency", ec, 4 * 3 + 1);

        wdata_q.push_back(16'hA5A5); wdata_q.push_back(16'h5A5A);
        run_xfer(1'b0, 16'h0300, 2, 100, 100, ec, fe);
        check_eq("wr2_latency", ec, 3 * 2 + 1);
        check_eq("wr2_mem0", 32'(mem_m[16'h0300]), 32'h0000A5A5);

        run_xfer(1'b1, 16'hFFFE, 2, 100, 100, ec, fe);
        check_eq("wrap_latency", ec, 4 * 2 + 1);

        run_xfer(1'b1, 16'h4000, 0, 100, 100, ec, fe);
        check_eq("zero_words_latency", ec, 1);

        stall_left = 5;
        run_xfer(1'b1, 16'h0400, 1, 100, 100, ec, fe);
        check_eq("stall_mem_en_cycles", fe, 6);
        check_eq("stall_latency", ec, 4 + 5 + 1);

        run_xfer(1'b0, 16'h1235, 3, 50, 60, ec, fe);
        run_xfer(1'b1, 16'h1235, 3, 70, 40, ec, fe);

        run_abort();
        run_xfer(1'b0, 16'h0C00, 2, 100, 100, ec, fe);
        check_eq("post_abort_latency", ec, 3 * 2 + 1);

        for (int t = 0; t < 25; t++) begin
            rd = 1'($urandom_range(1));
            n  = int'($urandom_range(6));
            stall_left = int'($urandom_range(3));
            run_xfer(rd, 16'($urandom), n, int'($urandom_range(100, 30)),
                     int'($urandom_range(100, 30)), ec, fe);
        end
        stall_left = 0;

        run_mid_reset();
        run_xfer(1'b1, 16'h0200, 3, 100, 100, ec, fe);
        check_eq("post_rst_latency", ec, 4 * 3 + 1);

`ifdef DMA_TIMEOUT_EN
        run_timeout();
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule
